// File: rtl/arvore_pkg.sv
// Shared types and default sizing for the Christmas-tree light scheduler.
package arvore_pkg;

  localparam int unsigned PAT_LEN_DEF = 8;
  localparam int unsigned DWELL_W_DEF = 16;
  localparam int unsigned REP_W_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/contador_espera.sv
// Loadable down-counter that times the dwell between scheduler steps.
module contador_espera #(
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [DWELL_W-1:0] value,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt;

  // Load has priority; otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - DWELL_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sequenciador_arvore.sv
// Replays a captured mode pattern for the tree light FSM, one step per dwell period.
module sequenciador_arvore
  import arvore_pkg::*;
#(
  parameter int unsigned PAT_LEN = PAT_LEN_DEF,
  parameter int unsigned DWELL_W = DWELL_W_DEF,
  parameter int unsigned REP_W   = REP_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic [PAT_LEN-1:0]         pattern,
  input  logic [$clog2(PAT_LEN)-1:0] len,
  input  logic [DWELL_W-1:0]         dwell,
  input  logic [REP_W-1:0]           reps,
  output logic                       m,
  output logic                       step,
  output logic [$clog2(PAT_LEN)-1:0] idx,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned IDX_W = $clog2(PAT_LEN);

  seq_state_t         state, state_n;
  logic [PAT_LEN-1:0] pat_q;
  logic [IDX_W-1:0]   len_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [REP_W-1:0]   reps_q;
  logic [REP_W-1:0]   rep_cnt, rep_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic               capture;
  logic               cnt_zero;

  contador_espera #(.DWELL_W(DWELL_W)) u_espera (
    .clk   (clk),
    .reset (reset),
    .load  (state == STEP),
    .value (dwell_q),
    .zero  (cnt_zero)
  );

  // State, index, repetition and shadow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx_q   <= '0;
      rep_cnt <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      dwell_q <= '0;
      reps_q  <= '0;
    end else begin
      state   <= state_n;
      idx_q   <= idx_n;
      rep_cnt <= rep_n;
      if (capture) begin
        pat_q   <= pattern;
        len_q   <= len;
        dwell_q <= dwell;
        reps_q  <= reps;
      end
    end
  end

  // Next-state, index and repetition decisions; stop overrides any active state.
  always_comb begin
    state_n = state;
    idx_n   = idx_q;
    rep_n   = rep_cnt;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          capture = 1'b1;
          idx_n   = '0;
          rep_n   = reps;
          state_n = STEP;
        end
      end
      STEP: state_n = WAIT;
      WAIT: begin
        if (cnt_zero) begin
          if (idx_q < len_q) begin
            idx_n   = idx_q + IDX_W'(1);
            state_n = STEP;
          end else begin
            idx_n = '0;
            if (reps_q == '0) begin
              state_n = STEP;
            end else if (rep_cnt == REP_W'(1)) begin
              state_n = DONE;
            end else begin
              rep_n   = rep_cnt - REP_W'(1);
              state_n = STEP;
            end
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (stop && (state != IDLE)) begin
      state_n = IDLE;
      idx_n   = '0;
    end
  end

  assign step = (state == STEP);
  assign busy = (state == STEP) || (state == WAIT);
  assign done = (state == DONE);
  assign idx  = idx_q;
  assign m    = busy ? pat_q[idx_q] : 1'b0;

endmodule

// File: tb/tb_sequenciador_arvore.sv
// Scoreboard bench for the tree light scheduler: table-driven runs plus corner sequences.
module tb_sequenciador_arvore;

  logic        clk = 1'b0;
  logic        reset, start, stop;
  logic [7:0]  pattern;
  logic [2:0]  len;
  logic [15:0] dwell;
  logic [3:0]  reps;
  logic        m, step, busy, done;
  logic [2:0]  idx;

  sequenciador_arvore #(.PAT_LEN(8), .DWELL_W(16), .REP_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .pattern (pattern),
    .len     (len),
    .dwell   (dwell),
    .reps    (reps),
    .m       (m),
    .step    (step),
    .idx     (idx),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic       m;
    logic [2:0] idx;
  } step_exp_t;

  typedef struct {
    logic [7:0]  pat;
    logic [2:0]  len;
    logic [15:0] dwell;
    logic [3:0]  reps;
    int          n_steps;
    int          period;
    int          done_off;
  } vec_t;

  step_exp_t step_q[$];
  int        done_q[$];
  int        tests = 0;
  int        fails = 0;
  step_exp_t e;
  int        d;

  // Scoreboard: every observed step/done must match the head of its queue.
  always @(negedge clk) begin
    if (step) begin
      tests++;
      if (step_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_step cyc=%0d m=%0b idx=%0d", cyc, m, idx);
      end else begin
        e = step_q.pop_front();
        if (e.at != cyc || e.m !== m || e.idx !== idx) begin
          fails++;
          $display("FAIL step_chk got cyc=%0d m=%0b idx=%0d, exp cyc=%0d m=%0b idx=%0d",
                   cyc, m, idx, e.at, e.m, e.idx);
        end
      end
    end
    if (done) begin
      tests++;
      if (done_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done cyc=%0d", cyc);
      end else begin
        d = done_q.pop_front();
        if (d != cyc) begin
          fails++;
          $display("FAIL done_chk got cyc=%0d, exp cyc=%0d", cyc, d);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Called at a negedge: drives the run, pushes expectations, drops start one cycle later.
  task automatic launch(input vec_t v, input int npush, input bit with_done, output int n);
    int l;
    pattern = v.pat;
    len     = v.len;
    dwell   = v.dwell;
    reps    = v.reps;
    start   = 1'b1;
    n       = cyc + 1;
    l       = int'(v.len) + 1;
    for (int j = 0; j < npush; j++) begin
      step_exp_t s;
      s.at  = n + j * v.period;
      s.m   = v.pat[j % l];
      s.idx = 3'(j % l);
      step_q.push_back(s);
    end
    if (with_done) done_q.push_back(n + v.done_off);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && (step_q.size() != 0 || done_q.size() != 0); i++)
      @(negedge clk);
    check({name, "_drain"}, 32'(step_q.size() + done_q.size()), 32'd0);
    step_q.delete();
    done_q.delete();
    @(negedge clk);
    check({name, "_busy_after"}, 32'(busy), 32'd0);
    check({name, "_idx_after"}, 32'(idx), 32'd0);
    check({name, "_m_after"}, 32'(m), 32'd0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  vec_t vecs[5];
  vec_t v;
  int   n;

  initial begin
    vecs[0] = '{8'b0000_0101, 3'd2, 16'd3, 4'd1, 3, 5, 15};
    vecs[1] = '{8'b0000_0010, 3'd1, 16'd0, 4'd3, 6, 2, 12};
    vecs[2] = '{8'b1011_0010, 3'd7, 16'd1, 4'd2, 16, 3, 48};
    vecs[3] = '{8'b0000_0001, 3'd0, 16'd0, 4'd1, 1, 2, 2};
    vecs[4] = '{8'b1000_0000, 3'd7, 16'd4, 4'd1, 8, 6, 48};

    reset = 1'b1; start = 1'b0; stop = 1'b0;
    pattern = '0; len = '0; dwell = '0; reps = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_m", 32'(m), 32'd0);
    check("rst_step", 32'(step), 32'd0);
    check("rst_idx", 32'(idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    for (int k = 0; k < 5; k++) begin
      launch(vecs[k], vecs[k].n_steps, 1'b1, n);
      drain($sformatf("vec%0d", k), vecs[k].done_off + 20);
      repeat (2) @(negedge clk);
    end

    // Infinite run, stopped mid-WAIT after 10 steps.
    v = '{8'b0000_0001, 3'd0, 16'd2, 4'd0, 0, 4, 0};
    launch(v, 10, 1'b0, n);
    while (cyc < n + 37) @(negedge clk);
    check("inf_busy_pre_stop", 32'(busy), 32'd1);
    stop = 1'b1;
    @(negedge clk);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_m", 32'(m), 32'd0);
    check("stop_step", 32'(step), 32'd0);
    check("stop_done", 32'(done), 32'd0);
    check("inf_steps_seen", 32'(step_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    stop = 1'b0;
    repeat (10) @(negedge clk);
    check("stop_stays_idle", 32'(busy), 32'd0);

    // Start re-asserted with new inputs during WAIT must not disturb the run.
    launch(vecs[0], vecs[0].n_steps, 1'b1, n);
    while (cyc < n + 2) @(negedge clk);
    pattern = 8'hFF; dwell = 16'd0; len = 3'd0; reps = 4'd5;
    start = 1'b1;
    repeat (6) @(negedge clk);
    start = 1'b0;
    drain("busy_start", 40);
    repeat (2) @(negedge clk);

    // Reset during STEP clears outputs; a later start replays from idx 0.
    v = '{8'b0000_0101, 3'd2, 16'd1, 4'd1, 3, 3, 9};
    launch(v, 1, 1'b0, n);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_step", 32'(step), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_m", 32'(m), 32'd0);
    check("rst_mid_idx", 32'(idx), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    launch(v, v.n_steps, 1'b1, n);
    drain("after_rst", 30);

    // start and stop together in IDLE: no launch; start alone next cycle launches.
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    check("ss_busy", 32'(busy), 32'd0);
    check("ss_step", 32'(step), 32'd0);
    stop = 1'b0;
    launch(vecs[3], vecs[3].n_steps, 1'b1, n);
    drain("ss_run", 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
